// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and depth derivation for the parametrised register file
package regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    // Number of registers addressed by an addr_w-bit address.
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending scoreboard with reservation and ready logic
//
// Ports:
//   clk_n, rst_n      falling-edge clock, async active-low reset
//   we, waddr         write port (clears pending of the written register)
//   rsv, raddr        reservation request (sets pending when accepted)
//   aaddr, baddr      read-port source addresses
//   rsv_ok            reservation accepted (combinational)
//   aready, bready    source not pending, or satisfied by the bypass
//   pending           scoreboard vector, bit i = register i pending
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = depth_of(ADDR_W_DEF),
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk_n,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [ADDR_W-1:0] aaddr,
    input  logic [ADDR_W-1:0] baddr,
    output logic              rsv_ok,
    output logic              aready,
    output logic              bready,
    output logic [DEPTH-1:0]  pending
);

    logic we_eff;
    logic rsv_set;

    // With a hard-wired zero register, address 0 never takes writes and never goes pending.
    assign we_eff  = we && !((ZERO_REG != 0) && (waddr == '0));

    // A write landing on the reserving edge hands the register straight to the new producer.
    assign rsv_ok  = rsv && (!pending[raddr] || (we && (waddr == raddr)));
    assign rsv_set = rsv_ok && !((ZERO_REG != 0) && (raddr == '0));

    assign aready = !pending[aaddr] || ((BYPASS != 0) && we_eff && (waddr == aaddr));
    assign bready = !pending[baddr] || ((BYPASS != 0) && we_eff && (waddr == baddr));

    // Reservation has priority over the clearing write on the same register.
    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rsv_set && (raddr == ADDR_W'(i))) begin
                    pending[i] <= 1'b1;
                end else if (we_eff && (waddr == ADDR_W'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/param_regfile.sv
// rtl/param_regfile.sv - parametrised register file with write bypass and hazard scoreboard
//
// Ports:
//   clk_n, rst_n            falling-edge clock, async active-low reset
//   WE, Waddr, Wdata        write port
//   Aaddr/Adata/Aready      read port A (combinational data, source-ready flag)
//   Baddr/Bdata/Bready      read port B
//   RSV, Raddr, rsv_ok      reservation request and acceptance
//   pending                 scoreboard vector
module param_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                        clk_n,
    input  logic                        rst_n,
    input  logic                        WE,
    input  logic [ADDR_W-1:0]           Waddr,
    input  logic [DATA_W-1:0]           Wdata,
    input  logic [ADDR_W-1:0]           Aaddr,
    input  logic [ADDR_W-1:0]           Baddr,
    output logic [DATA_W-1:0]           Adata,
    output logic [DATA_W-1:0]           Bdata,
    output logic                        Aready,
    output logic                        Bready,
    input  logic                        RSV,
    input  logic [ADDR_W-1:0]           Raddr,
    output logic                        rsv_ok,
    output logic [depth_of(ADDR_W)-1:0] pending
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we_eff;

    assign we_eff = WE && !((ZERO_REG != 0) && (Waddr == '0));

    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we_eff) begin
            mem[Waddr] <= Wdata;
        end
    end

    // Stored value, overridden by same-cycle write data, forced to zero for a hard-wired R0.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = mem[addr];
        if ((BYPASS != 0) && we_eff && (Waddr == addr)) begin
            val = Wdata;
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        Adata = read_port(Aaddr);
        Bdata = read_port(Baddr);
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk_n   (clk_n),
        .rst_n   (rst_n),
        .we      (WE),
        .waddr   (Waddr),
        .rsv     (RSV),
        .raddr   (Raddr),
        .aaddr   (Aaddr),
        .baddr   (Baddr),
        .rsv_ok  (rsv_ok),
        .aready  (Aready),
        .bready  (Bready),
        .pending (pending)
    );

endmodule

// File: tb/tb_param_regfile.sv
// tb/tb_param_regfile.sv - self-checking bench for param_regfile across four parameter sets
module tb_param_regfile;

    logic        clk_n;
    logic        rst_n;
    logic        we, rsv;
    logic [2:0]  waddr, aaddr, baddr, raddr;
    logic [15:0] wdata;

    // dut0: default (BYPASS=1, ZERO_REG=0); dut1: BYPASS=0; dut2: ZERO_REG=1
    logic [15:0] adata0, bdata0, adata1, bdata1, adata2, bdata2;
    logic        ardy0, brdy0, ardy1, brdy1, ardy2, brdy2;
    logic        ok0, ok1, ok2;
    logic [7:0]  pend0, pend1, pend2;

    // dut3: DATA_W=32, ADDR_W=4
    logic        we3;
    logic [3:0]  waddr3, aaddr3, baddr3;
    logic [31:0] wdata3, adata3, bdata3;
    logic        ardy3, brdy3, ok3;
    logic [15:0] pend3;

    int checks = 0;
    int errors = 0;

    param_regfile dut0 (
        .clk_n(clk_n), .rst_n(rst_n), .WE(we), .Waddr(waddr), .Wdata(wdata),
        .Aaddr(aaddr), .Baddr(baddr), .Adata(adata0), .Bdata(bdata0),
        .Aready(ardy0), .Bready(brdy0), .RSV(rsv), .Raddr(raddr),
        .rsv_ok(ok0), .pending(pend0)
    );

    param_regfile #(.BYPASS(0)) dut1 (
        .clk_n(clk_n), .rst_n(rst_n), .WE(we), .Waddr(waddr), .Wdata(wdata),
        .Aaddr(aaddr), .Baddr(baddr), .Adata(adata1), .Bdata(bdata1),
        .Aready(ardy1), .Bready(brdy1), .RSV(rsv), .Raddr(raddr),
        .rsv_ok(ok1), .pending(pend1)
    );

    param_regfile #(.ZERO_REG(1)) dut2 (
        .clk_n(clk_n), .rst_n(rst_n), .WE(we), .Waddr(waddr), .Wdata(wdata),
        .Aaddr(aaddr), .Baddr(baddr), .Adata(adata2), .Bdata(bdata2),
        .Aready(ardy2), .Bready(brdy2), .RSV(rsv), .Raddr(raddr),
        .rsv_ok(ok2), .pending(pend2)
    );

    param_regfile #(.DATA_W(32), .ADDR_W(4)) dut3 (
        .clk_n(clk_n), .rst_n(rst_n), .WE(we3), .Waddr(waddr3), .Wdata(wdata3),
        .Aaddr(aaddr3), .Baddr(baddr3), .Adata(adata3), .Bdata(bdata3),
        .Aready(ardy3), .Bready(brdy3), .RSV(1'b0), .Raddr(4'd0),
        .rsv_ok(ok3), .pending(pend3)
    );

    initial begin
        clk_n = 1'b1;
        forever #5 clk_n = ~clk_n;
    end

    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic [2:0]  aaddr;
        logic [2:0]  baddr;
        logic        rsv;
        logic [2:0]  raddr;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        ear;
        logic        ebr;
        logic        eok;
        logic [7:0]  ep;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 after the rising edge; checks run 2 later, well before the falling edge.
    task automatic drive(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [2:0] aa, input logic [2:0] ba,
                         input logic r, input logic [2:0] ra);
        @(posedge clk_n);
        #1;
        we = w; waddr = wa; wdata = wd; aaddr = aa; baddr = ba; rsv = r; raddr = ra;
        #2;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5, 1'b0, 3'd0, 16'hBEEF, 16'hBEEF, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd3, 1'b0, 3'd0, 16'hBEEF, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd5, 1'b1, 3'd2, 16'h0000, 16'hBEEF, 1'b1, 1'b1, 1'b1, 8'h00};
        vecs[4]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 1'b1, 3'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h04};
        vecs[5]  = '{1'b1, 3'd2, 16'h0042, 3'd2, 3'd5, 1'b0, 3'd0, 16'h0042, 16'hBEEF, 1'b1, 1'b1, 1'b0, 8'h04};
        vecs[6]  = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd2, 1'b0, 3'd0, 16'h0042, 16'h0042, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd6, 1'b1, 3'd6, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h00};
        vecs[8]  = '{1'b1, 3'd6, 16'h0F0F, 3'd6, 3'd2, 1'b1, 3'd6, 16'h0F0F, 16'h0042, 1'b1, 1'b1, 1'b1, 8'h40};
        vecs[9]  = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd6, 1'b0, 3'd0, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 1'b0, 8'h40};
        vecs[10] = '{1'b1, 3'd7, 16'h1111, 3'd7, 3'd3, 1'b1, 3'd3, 16'h1111, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h40};
        vecs[11] = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd3, 1'b0, 3'd0, 16'h1111, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h48};
        vecs[12] = '{1'b1, 3'd6, 16'hABCD, 3'd6, 3'd6, 1'b0, 3'd0, 16'hABCD, 16'hABCD, 1'b1, 1'b1, 1'b0, 8'h48};
        vecs[13] = '{1'b0, 3'd0, 16'h0000, 3'd6, 3'd3, 1'b0, 3'd0, 16'hABCD, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h08};

        rst_n = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0; aaddr = '0; baddr = '0; rsv = 1'b0; raddr = '0;
        we3 = 1'b0; waddr3 = '0; wdata3 = '0; aaddr3 = '0; baddr3 = '0;
        #2;
        check("reset_pending", 32'(pend0), 32'h0);
        check("reset_aready", 32'(ardy0), 32'h1);
        @(posedge clk_n);
        #1 rst_n = 1'b1;

        // Table: dut0 with bypass, RAW, WAW and simultaneous write+reserve.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].aaddr, vecs[i].baddr,
                  vecs[i].rsv, vecs[i].raddr);
            check($sformatf("v%0d_adata", i), 32'(adata0), 32'(vecs[i].ea));
            check($sformatf("v%0d_bdata", i), 32'(bdata0), 32'(vecs[i].eb));
            check($sformatf("v%0d_aready", i), 32'(ardy0), 32'(vecs[i].ear));
            check($sformatf("v%0d_bready", i), 32'(brdy0), 32'(vecs[i].ebr));
            check($sformatf("v%0d_rsv_ok", i), 32'(ok0), 32'(vecs[i].eok));
            check($sformatf("v%0d_pending", i), 32'(pend0), 32'(vecs[i].ep));
        end

        // Asynchronous reset mid-cycle discards data and reservations.
        drive(1'b1, 3'd3, 16'h1234, 3'd0, 3'd0, 1'b1, 3'd4);
        drive(1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 1'b1, 3'd4);
        check("pre_rst_adata", 32'(adata0), 32'h1234);
        check("pre_rst_pending", 32'(pend0), 32'h10);
        check("pre_rst_rsv_ok", 32'(ok0), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_adata", 32'(adata0), 32'h0);
        check("rst_bdata", 32'(bdata0), 32'h0);
        check("rst_pending", 32'(pend0), 32'h0);
        check("rst_aready", 32'(ardy0), 32'h1);
        check("rst_rsv_ok", 32'(ok0), 32'h1);
        @(posedge clk_n);
        #1 rst_n = 1'b1;
        we = 1'b0; rsv = 1'b0;

        // BYPASS=0: write data appears only after the falling edge.
        drive(1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd0, 1'b0, 3'd0);
        check("nobyp_same_cycle", 32'(adata1), 32'h0);
        check("byp_same_cycle", 32'(adata0), 32'hBEEF);
        drive(1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 1'b0, 3'd0);
        check("nobyp_after_edge", 32'(adata1), 32'hBEEF);
        drive(1'b0, 3'd0, 16'h0000, 3'd2, 3'd0, 1'b1, 3'd2);
        check("nobyp_rsv_ok", 32'(ok1), 32'h1);
        drive(1'b1, 3'd2, 16'h0042, 3'd2, 3'd0, 1'b0, 3'd0);
        check("nobyp_aready_pend", 32'(ardy1), 32'h0);
        check("byp_aready_fwd", 32'(ardy0), 32'h1);
        drive(1'b0, 3'd0, 16'h0000, 3'd2, 3'd0, 1'b0, 3'd0);
        check("nobyp_aready_after", 32'(ardy1), 32'h1);
        check("nobyp_adata_after", 32'(adata1), 32'h0042);
        check("nobyp_pending_after", 32'(pend1), 32'h0);

        // ZERO_REG=1: register 0 ignores writes, never goes pending.
        drive(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b0, 3'd0);
        check("zero_adata_wr", 32'(adata2), 32'h0);
        check("zero_bdata_wr", 32'(bdata2), 32'h0);
        check("nozero_adata_wr", 32'(adata0), 32'hFFFF);
        drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b1, 3'd0);
        check("zero_rsv_ok", 32'(ok2), 32'h1);
        check("zero_adata_after", 32'(adata2), 32'h0);
        check("nozero_adata_after", 32'(adata0), 32'hFFFF);
        drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 3'd0);
        check("zero_pending", 32'(pend2), 32'h0);
        check("zero_aready", 32'(ardy2), 32'h1);
        check("nozero_pending", 32'(pend0), 32'h01);
        check("nozero_aready", 32'(ardy0), 32'h0);

        // 32-bit x 16 instance: fill then read both ports over all addresses.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk_n);
            #1;
            we3 = 1'b1; waddr3 = 4'(i); wdata3 = 32'(i) * 32'h01010101;
        end
        @(posedge clk_n);
        #1 we3 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk_n);
            #1;
            aaddr3 = 4'(i); baddr3 = 4'(15 - i);
            #2;
            check($sformatf("w32_a%0d", i), adata3, 32'(i) * 32'h01010101);
            check($sformatf("w32_b%0d", 15 - i), bdata3, 32'(15 - i) * 32'h01010101);
        end
        check("w32_pending", 32'(pend3), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_regfile.md
# param_regfile

Parametrised successor to the 8×16 register file of the multicycle RISC core. Width and depth are configurable, with an optional hard-wired zero register. Adds write-to-read bypass and a per-register pending scoreboard, so the control FSM can detect RAW/WAW hazards when writeback is delayed. Sits between the decode/control unit and the ALU operand muxes.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes, never pending
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports
- clk_n  in  1  clock; all state updates on its falling edge
- rst_n  in  1  reset, asynchronous, active-low
- WE  in  1  write enable
- Waddr  in  ADDR_W  write address
- Wdata  in  DATA_W  write data
- Aaddr, Baddr  in  ADDR_W  read addresses A, B
- Adata, Bdata  out  DATA_W  read data A, B (combinational)
- Aready, Bready  out  1  source register A/B not pending (or bypassed)
- RSV  in  1  reserve request: mark Raddr pending (instruction issued, result outstanding)
- Raddr  in  ADDR_W  reservation address
- rsv_ok  out  1  reservation accepted (combinational)
- pending  out  DEPTH  scoreboard vector, bit i = register i pending

## Operation
- Storage: DEPTH × DATA_W registers, plus a DEPTH-bit pending vector.
- Write: on falling edge with WE=1, reg[Waddr] ← Wdata and pending[Waddr] ← 0. Writing a non-pending register is legal and is a plain write.
- Reserve:
  - rsv_ok = RSV & (~pending[Raddr] | (WE & Waddr==Raddr)).
  - On falling edge with rsv_ok=1, pending[Raddr] ← 1.
  - RSV with rsv_ok=0 (WAW hazard) has no effect; the controller must stall.
- Simultaneous WE and RSV to the same address: data is written and pending ends at 1, because the new producer wins.
- Read: Adata = reg[Aaddr]; if BYPASS=1 and WE=1 and Waddr==Aaddr, Adata = Wdata instead. Port B behaves the same.
- Ready: Aready = ~pending[Aaddr] | (BYPASS & WE & Waddr==Aaddr). Port B behaves the same.
- ZERO_REG=1, address 0:
  - reads return 0 and ready is 1;
  - WE to address 0 is ignored, and bypass does not apply;
  - RSV to address 0 gives rsv_ok=1 but does not set pending; pending[0] stays 0.
- Both read ports may address the same register; there is no port conflict.

## Timing
- Reset (rst_n low, no clock needed): all registers 0, pending all 0. Outputs: Adata = Bdata = 0, Aready = Bready = 1, rsv_ok = RSV. Reset mid-operation discards outstanding reservations.
- Release of rst_n takes effect at the next falling edge; the first write can occur on that edge.
- Read latency is 0 (combinational from address). Registered read data becomes visible after the falling edge that wrote it.
- Bypass path is combinational from WE/Waddr/Wdata to Adata/Bdata within the same cycle.
- Reserve-then-write on the same register needs at least one falling edge between them. A write on the reserving edge counts as the simultaneous case above.
- No internal FSM beyond per-register pending bits; each bit is a 2-state machine (FREE → PEND on accepted RSV, PEND → FREE on WE without same-address RSV).

## Structure
- Shared package `regfile_pkg`: default DATA_W/ADDR_W constants and DEPTH derivation function.
- Sub-module `regfile_scoreboard` holds the pending vector, rsv_ok logic and ready generation (DEPTH, ZERO_REG, BYPASS parameters).
- Top holds the data array with the write decode, bypass and read muxes.

## Test plan
- Reset: assert rst_n=0 mid-cycle after writing R3=16'h1234 → immediately Adata(R3)=0, pending=8'h00, Aready=1.
- Write/read: WE, Waddr=5, Wdata=16'hBEEF. With BYPASS=1, Aaddr=5 shows 16'hBEEF in the same cycle. With BYPASS=0, it shows 16'hBEEF only after the falling edge.
- Scoreboard RAW:
  - RSV Raddr=2 → pending=8'h04 and Aready(Aaddr=2)=0.
  - A second RSV to 2 gives rsv_ok=0 and pending is unchanged.
  - WE to 2 with 16'h0042 → pending=8'h00 and Aready=1.
- Simultaneous: WE Waddr=6 Wdata=16'h0F0F with RSV Raddr=6 while 6 is pending → rsv_ok=1, reg6=16'h0F0F, pending[6]=1 afterwards.
- ZERO_REG=1:
  - WE Waddr=0 Wdata=16'hFFFF → Adata(0)=0.
  - RSV Raddr=0 → rsv_ok=1, pending[0]=0.
- Parametrisation: DATA_W=32, ADDR_W=4, fill all 16 registers with i×32'h01010101 → read both ports across all addresses and match.
